apb_rr_arbiter: RTL
===================

APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, max ACCESS-phase wait cycles; 0 disables timeout.
REQ-004 SHALL have clk_i  input  1  single clock; all state in this domain.
REQ-005 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have mN_paddr_i (N=0,1)  input  ADDR_WIDTH  requester N address.
REQ-007 SHALL have mN_pwdata_i  input  DATA_WIDTH  requester N write data.
REQ-008 SHALL have mN_pwrite_i, mN_psel_i, mN_penable_i  input  1 each  requester N APB control.
REQ-009 SHALL have mN_prdata_o  output  DATA_WIDTH  read data to requester N.
REQ-010 SHALL have mN_pready_o, mN_pslverr_o  output  1 each  completion and error to requester N.
REQ-011 SHALL have s_paddr_o, s_pwdata_o, s_pwrite_o, s_psel_o, s_penable_o  output  ADDR_WIDTH/DATA_WIDTH/1/1/1  shared slave APB request.
REQ-012 SHALL have s_prdata_i, s_pready_i, s_pslverr_i  input  DATA_WIDTH/1/1  shared slave APB response.
REQ-013 SHALL have grant_o  output  2  one-hot current owner (bit N = requester N), 0 when idle.
REQ-014 SHALL have timeout_o  output  1  one-cycle pulse when a transfer is aborted by timeout.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-016 IDLE: request N pending iff mN_psel_i=1; with no request, remain IDLE.
REQ-017 IDLE, single pending request: grant it, capture its paddr/pwdata/pwrite into s_* registers, go SETUP next cycle.
REQ-018 IDLE, both pending: grant the requester not served last (round-robin); last_served resets to 1 so requester 0 wins first tie.
REQ-019 SETUP: s_psel_o=1, s_penable_o=0, for exactly one cycle, then ACCESS.
REQ-020 ACCESS: s_psel_o=1, s_penable_o=1; s_paddr_o/s_pwdata_o/s_pwrite_o stable from capture until leaving ACCESS.
REQ-021 ACCESS with s_pready_i=1: same cycle, combinationally drive granted mN_pready_o=1, mN_prdata_o=s_prdata_i, mN_pslverr_o=s_pslverr_i; update last_served; go IDLE.
REQ-022 Latency: requester psel in cycle T (IDLE) -> s_psel_o in T+1 -> s_penable_o in T+2 -> earliest requester pready in T+2.
REQ-023 Back-to-back: at least one IDLE cycle between transfers; a requester still asserting psel after its completion is a new request.
REQ-024 Non-granted requester SHALL see pready=0, prdata=0, pslverr=0; its psel is sampled only in IDLE.
REQ-025 Timeout counter: cleared on entry to ACCESS; increments each ACCESS cycle with s_pready_i=0; 8 bits minimum, width ceil(log2(TIMEOUT_CYCLES+1)).
REQ-026 Counter equal to TIMEOUT_CYCLES (nonzero) with s_pready_i=0: drive granted pready=1, pslverr=1, prdata=0, pulse timeout_o, go IDLE (slave access aborted).
REQ-027 s_pready_i=1 in the same cycle as timeout match: normal completion wins, no timeout_o.
REQ-028 s_* outputs registered; s_paddr_o/s_pwdata_o/s_pwrite_o hold last captured value in IDLE; s_psel_o=s_penable_o=0 in IDLE.
REQ-029 grant_o registered, nonzero exactly in SETUP and ACCESS.

Reset
REQ-030 rst_ni=0 SHALL immediately force IDLE, s_* outputs 0, grant_o=0, timeout_o=0, counter=0, last_served=1.
REQ-031 Reset mid-transfer SHALL abandon the transfer without any pready to requesters; first grant after release follows REQ-018.
REQ-032 All mN_* outputs SHALL read 0 during reset.

Verification
REQ-033 m0 write addr 0x1A10_0004 data 0xDEAD_BEEF, slave pready in first ACCESS cycle -> s_psel T+1, s_penable T+2, m0_pready=1 at T+2, grant_o=01.
REQ-034 m0 and m1 requesting same cycle, repeated 4 times -> grant order 0,1,0,1; no starvation.
REQ-035 m1 read, slave holds pready=0 for 5 cycles then pready=1, prdata 0x0000_00A5, pslverr=1 -> m1_prdata=0xA5, m1_pslverr=1, address stable all 6 ACCESS cycles.
REQ-036 TIMEOUT_CYCLES=4, slave never ready -> m0_pready=1, pslverr=1, timeout_o pulse, IDLE next cycle; TIMEOUT_CYCLES=0 -> waits indefinitely.
REQ-037 rst_ni low during ACCESS -> outputs 0 asynchronously, no requester pready; after release m0 granted first.
REQ-038 Timeout match coincident with s_pready_i=1 -> pslverr=s_pslverr_i, timeout_o=0.

Source files
------------

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: two APB requesters sharing one slave port.
// Round-robin on ties, optional ACCESS-phase timeout abort.
module apb_rr_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] m0_paddr_i,
  input  logic [DATA_WIDTH-1:0] m0_pwdata_i,
  input  logic                  m0_pwrite_i,
  input  logic                  m0_psel_i,
  input  logic                  m0_penable_i,
  output logic [DATA_WIDTH-1:0] m0_prdata_o,
  output logic                  m0_pready_o,
  output logic                  m0_pslverr_o,
  input  logic [ADDR_WIDTH-1:0] m1_paddr_i,
  input  logic [DATA_WIDTH-1:0] m1_pwdata_i,
  input  logic                  m1_pwrite_i,
  input  logic                  m1_psel_i,
  input  logic                  m1_penable_i,
  output logic [DATA_WIDTH-1:0] m1_prdata_o,
  output logic                  m1_pready_o,
  output logic                  m1_pslverr_o,
  output logic [ADDR_WIDTH-1:0] s_paddr_o,
  output logic [DATA_WIDTH-1:0] s_pwdata_o,
  output logic                  s_pwrite_o,
  output logic                  s_psel_o,
  output logic                  s_penable_o,
  input  logic [DATA_WIDTH-1:0] s_prdata_i,
  input  logic                  s_pready_i,
  input  logic                  s_pslverr_i,
  output logic [1:0]            grant_o,
  output logic                  timeout_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = (TW > 8) ? TW : 8;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      grant_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            capture;
  logic            pick;
  logic            done_ok;
  logic            to_hit;
  logic            done;
  logic            unused_penable;

  // Requester penable is implied by the arbiter's own phase tracking.
  assign unused_penable = m0_penable_i ^ m1_penable_i;

  assign done_ok = (state_q == ACCESS) & s_pready_i;
  assign to_hit  = TO_EN & (state_q == ACCESS) & ~s_pready_i
                 & (cnt_q == TO_MAX);
  assign done    = done_ok | to_hit;

  always_comb begin
    state_d = state_q;
    grant_d = grant_o;
    last_d  = last_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    pick    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0_psel_i | m1_psel_i) begin
          pick    = (m0_psel_i & m1_psel_i) ? ~last_q : m1_psel_i;
          grant_d = pick ? 2'b10 : 2'b01;
          capture = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (done) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = grant_o[1];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      grant_o     <= '0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      s_psel_o    <= 1'b0;
      s_penable_o <= 1'b0;
      s_paddr_o   <= '0;
      s_pwdata_o  <= '0;
      s_pwrite_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_o     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      s_psel_o    <= (state_d != IDLE);
      s_penable_o <= (state_d == ACCESS);
      if (capture) begin
        s_paddr_o  <= pick ? m1_paddr_i : m0_paddr_i;
        s_pwdata_o <= pick ? m1_pwdata_i : m0_pwdata_i;
        s_pwrite_o <= pick ? m1_pwrite_i : m0_pwrite_i;
      end
    end
  end

  // Response path is combinational so completion lands in the pready cycle.
  assign m0_pready_o  = grant_o[0] & done;
  assign m1_pready_o  = grant_o[1] & done;
  assign m0_prdata_o  = (grant_o[0] & done_ok) ? s_prdata_i : '0;
  assign m1_prdata_o  = (grant_o[1] & done_ok) ? s_prdata_i : '0;
  assign m0_pslverr_o = grant_o[0] & (done_ok ? s_pslverr_i : to_hit);
  assign m1_pslverr_o = grant_o[1] & (done_ok ? s_pslverr_i : to_hit);
  assign timeout_o    = to_hit;

endmodule
